add_share_arbiter: RTL and testbench
====================================

ADD_SHARE_ARBITER -- requirements
Module: add_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one adder.
REQ-002 Parameter DATA_W, default 9, SHALL set the signed operand and result width.
REQ-003 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port req_valid  input  NUM_REQ  SHALL flag a pending add request per requester.
REQ-006 Port req_ready  output  NUM_REQ  SHALL flag acceptance, per requester.
REQ-007 Port req_dataa  input  NUM_REQ*DATA_W  SHALL carry operand A per requester; requester i occupies slice i.
REQ-008 Port req_datab  input  NUM_REQ*DATA_W  SHALL carry operand B per requester; requester i occupies slice i.
REQ-009 Port rsp_valid  output  1  SHALL flag a valid result at the output.
REQ-010 Port rsp_ready  input  1  SHALL flag that the consumer takes the result.
REQ-011 Port rsp_id  output  clog2(NUM_REQ)  SHALL give the index of the requester that produced rsp_result.
REQ-012 Port rsp_result  output  DATA_W  SHALL carry the two's-complement sum.

Function
REQ-013 A request SHALL be accepted at an edge where req_valid[i] and req_ready[i] are both high; the requester holds its valid and operands stable until then.
REQ-014 At most one req_ready bit SHALL be high per cycle: the round-robin winner among valid requesters, and only when a credit is available.
REQ-015 Round-robin SHALL search from (last_granted+1) mod NUM_REQ upward; last_granted SHALL update only on acceptance.
REQ-016 Datapath SHALL be: operand mux, then a registered adder stage (in-flight, 0 or 1 entry), then a 3-entry output FIFO.
REQ-017 A credit SHALL exist when FIFO occupancy plus in-flight count is less than 3; req_ready SHALL NOT depend combinationally on rsp_ready.
REQ-018 Latency: for a request accepted at edge k, with the FIFO empty, rsp_valid SHALL first be high after edge k+1.
REQ-019 Throughput: with rsp_ready held high, one acceptance per cycle SHALL be sustained.
REQ-020 Results SHALL leave in acceptance order, each tagged with its rsp_id, with none dropped or duplicated.
REQ-021 rsp_valid SHALL stay high and rsp_id/rsp_result SHALL stay stable until rsp_ready is sampled high.
REQ-022 A FIFO push and pop at the same edge SHALL leave occupancy unchanged, including when the FIFO is full or has one entry.
REQ-023 Default arithmetic SHALL be rsp_result = (a + b) mod 2^DATA_W, i.e. two's-complement wrap with no saturation.
REQ-024 When no requester is valid or no credit exists, req_ready SHALL be all zero and last_granted SHALL hold.

Reset
REQ-025 While reset is high, these SHALL be 0: req_ready, rsp_valid, rsp_id, rsp_result, FIFO occupancy and in-flight count.
REQ-026 Reset SHALL set last_granted to NUM_REQ-1, so requester 0 wins first after release.
REQ-027 Reset mid-operation SHALL discard in-flight and buffered results; none SHALL appear after release.

Configuration
REQ-028 With macro ADD_SHARE_SAT_EN defined, the add SHALL saturate on signed overflow: to 2^(DATA_W-1)-1 when positive, to -2^(DATA_W-1) when negative.
REQ-029 Without ADD_SHARE_SAT_EN, wrap arithmetic per REQ-023 SHALL apply.
REQ-030 In both modes, ports and latency SHALL be identical.

Structure
REQ-031 Package add_share_pkg SHALL hold the NUM_REQ and DATA_W defaults, OUT_DEPTH=3, and the ID width constant.
REQ-032 Round-robin selection SHALL be a combinational sub-module, add_share_rr_pick (inputs: valid vector, last_granted; outputs: grant one-hot, grant index).

Verification
REQ-033 req0 only, a=0x1FF, b=0x1FF, rsp_ready=1 -> after edge k+1: rsp_valid=1, rsp_id=0, rsp_result=0x1FE.
REQ-034 req1 a=0x001, b=0x1FF -> 0x000; req3 a=0x025, b=0x1BE -> 0x1E3, in both modes.
REQ-035 req2 a=0x0FF, b=0x001 -> 0x100 without macro, 0x0FF with ADD_SHARE_SAT_EN; a=0x180, b=0x180 -> 0x100 in both modes.
REQ-036 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... with one acceptance per cycle and rsp_id in that order.
REQ-037 All valid, rsp_ready=0 -> exactly 3 acceptances, then req_ready=0; raising rsp_ready -> 3 results in order, then acceptance resumes.
REQ-038 Reset asserted with 2 results buffered -> rsp_valid=0 immediately; after release, first grant is to req0 and no stale result appears.

Source files
------------

// File: rtl/add_share_pkg.sv
`default_nettype none
// ============================================================================
// Module  : add_share_pkg
// Purpose : Shared constants and helpers for the shared-adder arbiter slice.
//           Holds the default requester count and data width, the output
//           FIFO depth, the requester-index width and a modulo-depth pointer
//           increment used by the output FIFO.
// Revision: 1.0 - initial release
// ============================================================================
package add_share_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 9;
    localparam int OUT_DEPTH   = 3;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

    // Pointer and occupancy widths for the 3-entry output FIFO
    localparam int PTR_W = 2;
    localparam int CNT_W = 2;

    // FIFO pointers wrap at OUT_DEPTH, which is not a power of two
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_share_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : add_share_rr_pick
// Purpose : Combinational round-robin picker. Searches the valid vector
//           starting one past last_granted and wrapping modulo NUM_REQ.
// Ports   : valid        - per-requester pending flags
//           last_granted - index of the most recently accepted requester
//           grant        - one-hot winner (all zero when nothing is valid)
//           grant_idx    - binary index of the winner
//           any_valid    - at least one requester is valid
// Revision: 1.0 - initial release
// ============================================================================
module add_share_rr_pick
    import add_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last_granted,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_valid
);

    int w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        w_cand    = 0;
        // Offset 1 first, so the last winner is considered only after
        // every other requester (offset NUM_REQ wraps back to itself).
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = (int'(last_granted) + off) % NUM_REQ;
            if (!any_valid && valid[w_cand]) begin
                any_valid     = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = ID_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : add_share_arbiter
// Purpose : NUM_REQ requesters share one adder. A round-robin winner's
//           operands are muxed into a registered adder stage (0/1 entry in
//           flight), whose result drains into a 3-entry output FIFO tagged
//           with the requester index. Acceptance is credit based: a request
//           is taken only while FIFO occupancy plus in-flight count is below
//           the FIFO depth, so the adder stage never stalls.
// Config  : ADD_SHARE_SAT_EN - when defined, the add saturates on signed
//           overflow instead of wrapping. Ports and latency are unchanged.
// Ports   : clock, reset (async, active high)
//           req_valid/req_ready      - per-requester handshake
//           req_dataa/req_datab      - packed operands, requester i at slice i
//           rsp_valid/rsp_ready      - result handshake
//           rsp_id/rsp_result        - requester index and sum
// Revision: 1.0 - initial release
// ============================================================================
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_dataa,
    input  logic [NUM_REQ*DATA_W-1:0] req_datab,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result
);

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_opa [NUM_REQ];
    logic [DATA_W-1:0] w_opb [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_opa[gi] = req_dataa[gi*DATA_W +: DATA_W];
            assign w_opb[gi] = req_datab[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration and credit
    // ------------------------------------------------------------------
    logic [ID_W-1:0]    r_last_granted;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;

    add_share_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid        (req_valid),
        .last_granted (r_last_granted),
        .grant        (w_grant),
        .grant_idx    (w_idx),
        .any_valid    (w_any)
    );

    logic               r_inf_valid;
    logic [ID_W-1:0]    r_inf_id;
    logic [DATA_W-1:0]  r_inf_sum;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W:0]     w_occ;
    logic               w_credit;
    logic               w_accept;

    // Credit looks only at registered occupancy, never at rsp_ready, so a
    // slot freed by a pop is offered one cycle later.
    assign w_occ     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inf_valid};
    assign w_credit  = (w_occ < (CNT_W+1)'(OUT_DEPTH));
    assign w_accept  = w_any && w_credit && !reset;
    assign req_ready = w_accept ? w_grant : '0;

    // ------------------------------------------------------------------
    // Operand mux and adder
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [DATA_W-1:0] w_sum;

    assign w_sel_a = w_opa[w_idx];
    assign w_sel_b = w_opb[w_idx];

`ifdef ADD_SHARE_SAT_EN
    // One guard bit: overflow when the top two bits of the extended sum
    // disagree; the guard bit then gives the true sign.
    logic [DATA_W:0] w_sum_ext;

    assign w_sum_ext = {w_sel_a[DATA_W-1], w_sel_a} + {w_sel_b[DATA_W-1], w_sel_b};

    always_comb begin
        w_sum = w_sum_ext[DATA_W-1:0];
        if (w_sum_ext[DATA_W] != w_sum_ext[DATA_W-1]) begin
            w_sum = w_sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign w_sum = w_sel_a + w_sel_b;
`endif

    // ------------------------------------------------------------------
    // Adder register stage and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inf_valid    <= 1'b0;
            r_inf_id       <= '0;
            r_inf_sum      <= '0;
            r_last_granted <= ID_W'(NUM_REQ - 1);
        end else begin
            r_inf_valid <= w_accept;
            if (w_accept) begin
                r_inf_id       <= w_idx;
                r_inf_sum      <= w_sum;
                r_last_granted <= w_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. The credit scheme guarantees room for every push.
    // ------------------------------------------------------------------
    logic [ID_W-1:0]   r_fifo_id   [OUT_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [OUT_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign w_push = r_inf_valid;
    assign w_pop  = (r_count != '0) && rsp_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_fifo_id[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_id[r_wr_ptr]   <= r_inf_id;
                r_fifo_data[r_wr_ptr] <= r_inf_sum;
                r_wr_ptr              <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rsp_valid  = (r_count != '0);
    assign rsp_id     = r_fifo_id[r_rd_ptr];
    assign rsp_result = r_fifo_data[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_add_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_share_arbiter
// Purpose : Directed self-checking bench for add_share_arbiter with
//           hand-computed expected sums, grant order and FIFO behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_add_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 9;
    localparam int ID_W    = 2;

`ifdef ADD_SHARE_SAT_EN
    localparam logic [DATA_W-1:0] EXP_OVF = 9'h0FF;
`else
    localparam logic [DATA_W-1:0] EXP_OVF = 9'h100;
`endif

    logic                      clock;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_dataa;
    logic [NUM_REQ*DATA_W-1:0] req_datab;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;

    int n_tests = 0;
    int n_fail  = 0;

    // Operands for multi-requester runs: a_i = 0x10*i + 1, b_i = 3
    logic [DATA_W-1:0] tab_a   [NUM_REQ];
    logic [DATA_W-1:0] tab_b   [NUM_REQ];
    logic [DATA_W-1:0] tab_exp [NUM_REQ];

    add_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req_dataa[i*DATA_W +: DATA_W] = a;
        req_datab[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic single(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [DATA_W-1:0] exp, input string tag);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        set_op(i, a, b);
        rsp_ready    = 1'b1;
        #1;
        check_eq({tag, "_rdy"}, 32'(req_ready), 32'(1 << i));
        step();
        req_valid = '0;
        check_eq({tag, "_early"}, 32'(rsp_valid), 32'd0);
        step();
        check_eq({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_id"},  32'(rsp_id), 32'(i));
        check_eq({tag, "_res"}, 32'(rsp_result), 32'(exp));
        step();
        check_eq({tag, "_drain"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int acc;

        for (int i = 0; i < NUM_REQ; i++) begin
            tab_a[i] = DATA_W'(16 * i + 1);
            tab_b[i] = 9'h003;
        end
        tab_exp[0] = 9'h004;
        tab_exp[1] = 9'h014;
        tab_exp[2] = 9'h024;
        tab_exp[3] = 9'h034;

        // ---------------- Reset state ----------------
        reset     = 1'b1;
        req_valid = '1;
        req_dataa = '0;
        req_datab = '0;
        rsp_ready = 1'b0;
        step();
        step();
        check_eq("rst_ready",  32'(req_ready),  32'd0);
        check_eq("rst_valid",  32'(rsp_valid),  32'd0);
        check_eq("rst_id",     32'(rsp_id),     32'd0);
        check_eq("rst_result", 32'(rsp_result), 32'd0);
        reset     = 1'b0;
        req_valid = '0;

        // ---------------- Single requests, arithmetic ----------------
        single(0, 9'h1FF, 9'h1FF, 9'h1FE, "r0_neg");
        single(1, 9'h001, 9'h1FF, 9'h000, "r1_zero");
        single(3, 9'h025, 9'h1BE, 9'h1E3, "r3_mix");
        single(2, 9'h0FF, 9'h001, EXP_OVF, "r2_ovf");
        single(2, 9'h180, 9'h180, 9'h100, "r2_minneg");

        // ---------------- Round robin at full throughput ----------------
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, tab_a[i], tab_b[i]);
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        for (int n = 0; n < 9; n++) begin
            check_eq($sformatf("rr_grant%0d", n), 32'(req_ready), 32'(1 << (n % NUM_REQ)));
            step();
            if (n > 0) begin
                check_eq($sformatf("rr_vld%0d", n), 32'(rsp_valid), 32'd1);
                check_eq($sformatf("rr_id%0d", n),  32'(rsp_id), 32'((n - 1) % NUM_REQ));
                check_eq($sformatf("rr_res%0d", n), 32'(rsp_result), 32'(tab_exp[(n - 1) % NUM_REQ]));
            end
        end

        // ---------------- Back-pressure and credit ----------------
        req_valid = '0;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        #1;
        acc = 0;
        for (int n = 0; n < 6; n++) begin
            if (req_ready != '0) acc++;
            step();
        end
        check_eq("bp_accepts", 32'(acc), 32'd3);
        check_eq("bp_noready", 32'(req_ready), 32'd0);
        check_eq("bp_hold_vld", 32'(rsp_valid), 32'd1);
        check_eq("bp_hold_id",  32'(rsp_id), 32'd0);
        check_eq("bp_hold_res", 32'(rsp_result), 32'(tab_exp[0]));
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_ready_comb", 32'(req_ready), 32'd0);
        step();
        check_eq("bp_id1",     32'(rsp_id), 32'd1);
        check_eq("bp_res1",    32'(rsp_result), 32'(tab_exp[1]));
        check_eq("bp_resume",  32'(req_ready), 32'b1000);
        step();
        check_eq("bp_id2",     32'(rsp_id), 32'd2);
        check_eq("bp_res2",    32'(rsp_result), 32'(tab_exp[2]));
        step();
        check_eq("bp_id3",     32'(rsp_id), 32'd3);
        check_eq("bp_res3",    32'(rsp_result), 32'(tab_exp[3]));

        // ---------------- Reset mid-operation ----------------
        req_valid = '0;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = '1;
        step();
        step();
        req_valid = '0;
        step();
        check_eq("mr_buffered", 32'(rsp_valid), 32'd1);
        req_valid = '1;
        #2;
        reset = 1'b1;
        #1;
        check_eq("mr_rsp_clr", 32'(rsp_valid), 32'd0);
        check_eq("mr_rdy_clr", 32'(req_ready), 32'd0);
        check_eq("mr_res_clr", 32'(rsp_result), 32'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check_eq("mr_first_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq($sformatf("mr_stale%0d", n), 32'(rsp_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
